// File: rtl/multicycle_control_if.sv
// Control-side bundle of the multicycle MIPS datapath: instruction fields and
// status going into the control FSM, strobes and selects coming back out.
// The memory handshake is level based: the memory holds mem_ready high in the
// one cycle in which it completes the access that mem_read/mem_write
// requests. The controller keeps its strobes asserted until it sees that cycle.
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             mem_read;
    logic             mem_write;
    logic             iord;
    logic             ir_write;
    logic             pc_write;
    logic [1:0]       pc_source;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [3:0]       alu_op;
    logic             reg_write;
    logic [1:0]       reg_dst;
    logic [1:0]       mem_to_reg;
    logic             illegal_op;
    logic             retire;
    logic [CNT_W-1:0] instr_count;
    logic [3:0]       state;

    // Datapath/testbench side: drives instruction fields, observes control.
    modport master (
        output run, opcode, funct, zero, mem_ready,
        input  mem_read, mem_write, iord, ir_write, pc_write, pc_source,
               alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
               illegal_op, retire, instr_count, state
    );

    // Control FSM side.
    modport slave (
        input  run, opcode, funct, zero, mem_ready,
        output mem_read, mem_write, iord, ir_write, pc_write, pc_source,
               alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
               illegal_op, retire, instr_count, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Control FSM for the multicycle MIPS datapath. Each instruction walks
// FETCH -> DECODE -> execute/memory -> writeback, then returns to FETCH.
// FETCH, MEM_RD and MEM_WR wait on mem_ready. BRANCH resolves pc_write
// from the zero flag in the same cycle. Every completed instruction
// pulses retire and bumps a wrapping counter.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input logic                  clk,
    input logic                  reset,
    multicycle_control_if.slave  bus
);
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_WB_ALU   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JR       = 4'd12,
        S_JAL      = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_t           state_q, state_d;
    logic [1:0]       reg_dst_q, reg_dst_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign bus.state       = state_q;
    assign bus.instr_count = count_q;

    // State, remembered write-back destination and retire counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            reg_dst_q <= 2'b00;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            reg_dst_q <= reg_dst_d;
            count_q   <= count_d;
        end
    end

    // Next state and all control outputs; everything defaults low each cycle.
    always_comb begin
        state_d        = state_q;
        reg_dst_d      = reg_dst_q;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.iord       = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_source  = 2'b00;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 4'b0000;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 2'b00;
        bus.mem_to_reg = 2'b00;
        bus.illegal_op = 1'b0;
        bus.retire     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.run) state_d = S_FETCH;
            end
            S_FETCH: begin
                // PC+4 computed every cycle; IR/PC only load on the ready cycle.
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_d      = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculative branch target lands in ALUOut.
                bus.alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_RTYPE:                      state_d = (bus.funct == FN_JR) ? S_JR : S_EXEC_R;
                    OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: state_d = S_EXEC_I;
                    OP_LW, OP_SW:                  state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                state_d = S_BRANCH;
                    OP_J:                          state_d = S_JUMP;
                    OP_JAL:                        state_d = S_JAL;
                    default: begin
                        bus.illegal_op = 1'b1;
                        state_d        = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 4'b0111;
                reg_dst_d     = 2'b01;
                state_d       = S_WB_ALU;
            end
            S_EXEC_I: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                case (bus.opcode)
                    OP_ORI:  bus.alu_op = 4'b0001;
                    OP_ANDI: bus.alu_op = 4'b0010;
                    OP_LUI:  bus.alu_op = 4'b0011;
                    default: bus.alu_op = 4'b0000;
                endcase
                reg_dst_d = 2'b00;
                state_d   = S_WB_ALU;
            end
            S_WB_ALU: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = reg_dst_q;
                bus.retire    = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                if (bus.opcode == OP_LW) begin
                    bus.alu_op = 4'b0100;
                    state_d    = S_MEM_RD;
                end else begin
                    bus.alu_op = 4'b0101;
                    state_d    = S_MEM_WR;
                end
            end
            S_MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
                if (bus.mem_ready) state_d = S_WB_MEM;
            end
            S_WB_MEM: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 2'b01;
                bus.retire     = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEM_WR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
                if (bus.mem_ready) begin
                    bus.retire = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.pc_source = 2'b01;
                if (bus.opcode == OP_BNE) begin
                    bus.alu_op   = 4'b1001;
                    bus.pc_write = ~bus.zero;
                end else begin
                    bus.alu_op   = 4'b1000;
                    bus.pc_write = bus.zero;
                end
                bus.retire = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_source = 2'b10;
                bus.pc_write  = 1'b1;
                bus.retire    = 1'b1;
                state_d       = S_FETCH;
            end
            S_JR: begin
                bus.pc_source = 2'b11;
                bus.pc_write  = 1'b1;
                bus.retire    = 1'b1;
                state_d       = S_FETCH;
            end
            S_JAL: begin
                // PC already holds PC+4, which is the link value written to $31.
                bus.pc_source  = 2'b10;
                bus.pc_write   = 1'b1;
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 2'b10;
                bus.mem_to_reg = 2'b10;
                bus.retire     = 1'b1;
                state_d        = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Retired-instruction count, wrapping naturally at all-ones.
    always_comb begin
        count_d = count_q;
        if (bus.retire) count_d = count_q + CNT_W'(1);
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a per-instruction model expands each
// instruction into its expected per-cycle control pattern. A compare process
// checks every cycle on the falling edge. Literal checks pin the reset state
// and counter values.
module tb_multicycle_control;
    localparam int CNT_W = 4;

    localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, EXEC_R = 4'd3,
                           EXEC_I = 4'd4, MEM_ADDR = 4'd5, MEM_RD = 4'd6, MEM_WR = 4'd7,
                           WB_MEM = 4'd8, WB_ALU = 4'd9, BRANCH = 4'd10, JUMP = 4'd11,
                           JR = 4'd12, JAL = 4'd13;

    typedef struct packed {
        logic [3:0]       state;
        logic             mem_read;
        logic             mem_write;
        logic             iord;
        logic             ir_write;
        logic             pc_write;
        logic [1:0]       pc_source;
        logic             alu_src_a;
        logic [1:0]       alu_src_b;
        logic [3:0]       alu_op;
        logic             reg_write;
        logic [1:0]       reg_dst;
        logic [1:0]       mem_to_reg;
        logic             illegal_op;
        logic             retire;
        logic [CNT_W-1:0] instr_count;
    } obs_t;

    localparam int W = $bits(obs_t);

    logic clk;
    logic reset;
    multicycle_control_if #(.CNT_W(CNT_W)) bus ();

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           model_count = 0;

    function automatic obs_t sample();
        obs_t o;
        o.state       = bus.state;
        o.mem_read    = bus.mem_read;
        o.mem_write   = bus.mem_write;
        o.iord        = bus.iord;
        o.ir_write    = bus.ir_write;
        o.pc_write    = bus.pc_write;
        o.pc_source   = bus.pc_source;
        o.alu_src_a   = bus.alu_src_a;
        o.alu_src_b   = bus.alu_src_b;
        o.alu_op      = bus.alu_op;
        o.reg_write   = bus.reg_write;
        o.reg_dst     = bus.reg_dst;
        o.mem_to_reg  = bus.mem_to_reg;
        o.illegal_op  = bus.illegal_op;
        o.retire      = bus.retire;
        o.instr_count = bus.instr_count;
        return o;
    endfunction

    // compare process: one expectation per clock cycle, checked mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t  e;
            obs_t  g;
            string nm;
            e  = obs_t'(exp_q.pop_front());
            nm = name_q.pop_front();
            g  = sample();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL %s @%0t: got state=%0d vec=%h, expected state=%0d vec=%h",
                         nm, $time, g.state, g, e.state, e);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    // model: all outputs low, state code, counter as retired so far
    function automatic obs_t blank(input logic [3:0] st);
        obs_t e;
        e             = '0;
        e.state       = st;
        e.instr_count = CNT_W'(model_count);
        return e;
    endfunction

    task automatic step(input obs_t e, input string nm);
        exp_q.push_back(W'(e));
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic retire_step(input obs_t e, input string nm);
        e.retire = 1'b1;
        step(e, nm);
        model_count++;
    endtask

    task automatic rnd_ready();
        bus.mem_ready = 1'($urandom_range(0, 1));
    endtask

    // driver: fetch with a given number of wait cycles
    task automatic do_fetch(input int waits);
        obs_t e;
        for (int i = 0; i < waits; i++) begin
            bus.mem_ready = 1'b0;
            e = blank(FETCH);
            e.mem_read  = 1'b1;
            e.alu_src_b = 2'b01;
            step(e, "fetch_wait");
        end
        bus.mem_ready = 1'b1;
        e = blank(FETCH);
        e.mem_read  = 1'b1;
        e.alu_src_b = 2'b01;
        e.ir_write  = 1'b1;
        e.pc_write  = 1'b1;
        step(e, "fetch");
    endtask

    // driver + model: one whole instruction from FETCH to its last cycle
    task automatic exec_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                              input int fwait, input int mwait);
        obs_t e;
        bus.opcode = op;
        bus.funct  = fn;
        bus.zero   = z;
        do_fetch(fwait);
        rnd_ready();
        e = blank(DECODE);
        e.alu_src_b = 2'b11;
        case (op)
            6'h00: begin
                step(e, "decode");
                rnd_ready();
                if (fn == 6'h08) begin
                    e = blank(JR);
                    e.pc_source = 2'b11;
                    e.pc_write  = 1'b1;
                    retire_step(e, "jr");
                end else begin
                    e = blank(EXEC_R);
                    e.alu_src_a = 1'b1;
                    e.alu_op    = 4'b0111;
                    step(e, "exec_r");
                    rnd_ready();
                    e = blank(WB_ALU);
                    e.reg_write = 1'b1;
                    e.reg_dst   = 2'b01;
                    retire_step(e, "wb_alu_r");
                end
            end
            6'h08, 6'h0d, 6'h0c, 6'h0f: begin
                step(e, "decode");
                rnd_ready();
                e = blank(EXEC_I);
                e.alu_src_a = 1'b1;
                e.alu_src_b = 2'b10;
                e.alu_op    = (op == 6'h08) ? 4'd0 : (op == 6'h0d) ? 4'd1 :
                              (op == 6'h0c) ? 4'd2 : 4'd3;
                step(e, "exec_i");
                rnd_ready();
                e = blank(WB_ALU);
                e.reg_write = 1'b1;
                retire_step(e, "wb_alu_i");
            end
            6'h23, 6'h2b: begin
                step(e, "decode");
                rnd_ready();
                e = blank(MEM_ADDR);
                e.alu_src_a = 1'b1;
                e.alu_src_b = 2'b10;
                e.alu_op    = (op == 6'h23) ? 4'b0100 : 4'b0101;
                step(e, "mem_addr");
                for (int i = 0; i <= mwait; i++) begin
                    bus.mem_ready = (i == mwait);
                    if (op == 6'h23) begin
                        e = blank(MEM_RD);
                        e.mem_read = 1'b1;
                        e.iord     = 1'b1;
                        step(e, "mem_rd");
                    end else begin
                        e = blank(MEM_WR);
                        e.mem_write = 1'b1;
                        e.iord      = 1'b1;
                        if (i == mwait) retire_step(e, "mem_wr_done");
                        else step(e, "mem_wr_wait");
                    end
                end
                if (op == 6'h23) begin
                    rnd_ready();
                    e = blank(WB_MEM);
                    e.reg_write  = 1'b1;
                    e.mem_to_reg = 2'b01;
                    retire_step(e, "wb_mem");
                end
            end
            6'h04, 6'h05: begin
                step(e, "decode");
                rnd_ready();
                e = blank(BRANCH);
                e.alu_src_a = 1'b1;
                e.pc_source = 2'b01;
                e.alu_op    = (op == 6'h04) ? 4'b1000 : 4'b1001;
                e.pc_write  = (op == 6'h04) ? z : !z;
                retire_step(e, "branch");
            end
            6'h02: begin
                step(e, "decode");
                rnd_ready();
                e = blank(JUMP);
                e.pc_source = 2'b10;
                e.pc_write  = 1'b1;
                retire_step(e, "jump");
            end
            6'h03: begin
                step(e, "decode");
                rnd_ready();
                e = blank(JAL);
                e.pc_source  = 2'b10;
                e.pc_write   = 1'b1;
                e.reg_write  = 1'b1;
                e.reg_dst    = 2'b10;
                e.mem_to_reg = 2'b10;
                retire_step(e, "jal");
            end
            default: begin
                e.illegal_op = 1'b1;
                step(e, "decode_illegal");
            end
        endcase
    endtask

    // directed instruction table for the post-reset run
    logic [5:0] tab_op[8] = '{6'h00, 6'h08, 6'h0d, 6'h2b, 6'h04, 6'h02, 6'h03, 6'h23};
    logic [5:0] tab_fn[8] = '{6'h25, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    initial begin
        reset         = 1'b1;
        bus.run       = 1'b0;
        bus.opcode    = 6'h00;
        bus.funct     = 6'h00;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 32'(bus.state), 32'd0);
        chk("reset_count", 32'(bus.instr_count), 32'd0);
        chk("reset_mem_read", 32'(bus.mem_read), 32'd0);
        reset = 1'b0;

        step(blank(IDLE), "idle_no_run");
        bus.run = 1'b1;
        step(blank(IDLE), "idle_run");

        exec_instr(6'h00, 6'h20, 1'b0, 0, 0);           // ADD
        chk("count_after_add", 32'(bus.instr_count), 32'd1);
        exec_instr(6'h23, 6'h00, 1'b0, 0, 3);           // LW, 3 wait cycles
        exec_instr(6'h2b, 6'h00, 1'b1, 2, 2);           // SW, fetch and write waits
        exec_instr(6'h04, 6'h00, 1'b1, 0, 0);           // BEQ taken
        exec_instr(6'h04, 6'h00, 1'b0, 1, 0);           // BEQ not taken
        exec_instr(6'h05, 6'h00, 1'b1, 0, 0);           // BNE not taken
        exec_instr(6'h05, 6'h00, 1'b0, 0, 0);           // BNE taken
        exec_instr(6'h00, 6'h08, 1'b0, 0, 0);           // JR
        exec_instr(6'h02, 6'h00, 1'b0, 0, 0);           // J
        exec_instr(6'h03, 6'h00, 1'b0, 0, 0);           // JAL
        exec_instr(6'h08, 6'h00, 1'b0, 0, 0);           // ADDI
        exec_instr(6'h0d, 6'h00, 1'b0, 0, 0);           // ORI
        exec_instr(6'h0c, 6'h00, 1'b0, 0, 0);           // ANDI
        exec_instr(6'h0f, 6'h00, 1'b0, 0, 0);           // LUI
        exec_instr(6'h00, 6'h22, 1'b1, 0, 0);           // SUB
        chk("count_15", 32'(bus.instr_count), 32'd15);
        exec_instr(6'h3f, 6'h00, 1'b0, 0, 0);           // illegal opcode
        chk("count_after_illegal", 32'(bus.instr_count), 32'd15);
        exec_instr(6'h00, 6'h20, 1'b0, 0, 0);           // 16th retire wraps
        chk("count_wrap", 32'(bus.instr_count), 32'd0);
        exec_instr(6'h08, 6'h00, 1'b0, 0, 0);
        chk("count_after_wrap", 32'(bus.instr_count), 32'd1);

        // asynchronous reset while FETCH waits on memory
        bus.run       = 1'b0;
        bus.mem_ready = 1'b0;
        begin
            obs_t e;
            e = blank(FETCH);
            e.mem_read  = 1'b1;
            e.alu_src_b = 2'b01;
            step(e, "fetch_before_reset");
        end
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_state", 32'(bus.state), 32'd0);
        chk("async_reset_mem_read", 32'(bus.mem_read), 32'd0);
        chk("async_reset_count", 32'(bus.instr_count), 32'd0);
        @(posedge clk);
        #1;
        reset       = 1'b0;
        model_count = 0;
        bus.run     = 1'b1;
        step(blank(IDLE), "idle_after_reset");

        for (int i = 0; i < 16; i++)
            exec_instr(tab_op[i % 8], tab_fn[i % 8], 1'($urandom_range(0, 1)),
                       $urandom_range(0, 2), $urandom_range(0, 2));
        chk("count_wrap_after_16", 32'(bus.instr_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
